// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB one instruction at a time.
// Outputs are combinational from state and ins; lw/sw stall MEM_WAIT extra cycles in the memory state.
module mc_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic        zero,
    output logic        pcWr,
    output logic        irWr,
    output logic        regWr,
    output logic        memWr,
    output logic [1:0]  regDst,
    output logic        aluSrc,
    output logic [4:0]  aluOp,
    output logic        extOp,
    output logic [1:0]  memToReg,
    output logic [1:0]  npcSel,
    output logic [3:0]  state,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_MEM  = 4'd7,
        S_WB_ALU  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_LUI = 5'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     cur;
    logic [3:0] cnt;
    logic [5:0] op;
    logic [5:0] funct;
    logic       is_rtype;
    logic       r_arith;
    logic       is_jr;
    logic       i_arith;
    logic       is_mem;
    logic       is_lw;
    logic       is_beq;
    logic       is_j;
    logic       is_jal;
    logic       supported;
    logic       cnt_done;
    logic [4:0] alu_r;
    logic [4:0] alu_i;
    logic       ext_i;
    logic       unused_ins;

    assign op         = ins[31:26];
    assign funct      = ins[5:0];
    assign unused_ins = ^ins[25:6];

    assign is_rtype = (op == OP_RTYPE);
    assign r_arith  = is_rtype && (funct == FN_ADDU || funct == FN_SUBU || funct == FN_AND ||
                                   funct == FN_OR   || funct == FN_SLT  || funct == FN_SLL);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign i_arith  = (op == OP_ORI) || (op == OP_ADDIU) || (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_mem   = is_lw || (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign supported = r_arith || is_jr || i_arith || is_mem || is_beq || is_j || is_jal;
    assign cnt_done = (cnt == WAIT_LAST);

    always_comb begin
        alu_r = ALU_ADD;
        case (funct)
            FN_ADDU: alu_r = ALU_ADD;
            FN_SUBU: alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_SLT:  alu_r = ALU_SLT;
            FN_SLL:  alu_r = ALU_SLL;
            default: alu_r = ALU_ADD;
        endcase
    end

    // ori zero-extends, addiu sign-extends, lui ignores the extender.
    always_comb begin
        alu_i = ALU_ADD;
        ext_i = 1'b0;
        case (op)
            OP_ORI:   alu_i = ALU_OR;
            OP_ADDIU: begin alu_i = ALU_ADD; ext_i = 1'b1; end
            OP_LUI:   alu_i = ALU_LUI;
            default:  alu_i = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_FETCH;
            cnt <= 4'd0;
        end else begin
            cnt <= 4'd0;
            case (cur)
                S_FETCH:  cur <= S_DECODE;
                S_DECODE: begin
                    if (r_arith)            cur <= S_EXE_R;
                    else if (i_arith)       cur <= S_EXE_I;
                    else if (is_mem)        cur <= S_MEM_ADR;
                    else if (is_beq)        cur <= S_BRANCH;
                    else if (is_j || is_jal || is_jr) cur <= S_JUMP;
                    else                    cur <= S_FETCH;
                end
                S_EXE_R:   cur <= S_WB_ALU;
                S_EXE_I:   cur <= S_WB_ALU;
                S_MEM_ADR: cur <= is_lw ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (cnt_done) cur <= S_WB_MEM;
                    else          cnt <= cnt + 4'd1;
                end
                S_MEM_WR: begin
                    if (cnt_done) cur <= S_FETCH;
                    else          cnt <= cnt + 4'd1;
                end
                S_WB_MEM:  cur <= S_FETCH;
                S_WB_ALU:  cur <= S_FETCH;
                S_BRANCH:  cur <= S_FETCH;
                S_JUMP:    cur <= S_FETCH;
                default:   cur <= S_FETCH;
            endcase
        end
    end

    assign state = cur;

    always_comb begin
        pcWr     = 1'b0;
        irWr     = 1'b0;
        regWr    = 1'b0;
        memWr    = 1'b0;
        regDst   = 2'b00;
        aluSrc   = 1'b0;
        aluOp    = ALU_ADD;
        extOp    = 1'b0;
        memToReg = 2'b00;
        npcSel   = 2'b00;
        illegal  = 1'b0;
        case (cur)
            S_FETCH: begin
                irWr = 1'b1;
                pcWr = 1'b1;
            end
            S_DECODE: illegal = !supported;
            S_EXE_R:  aluOp = alu_r;
            S_EXE_I: begin
                aluSrc = 1'b1;
                aluOp  = alu_i;
                extOp  = ext_i;
            end
            S_WB_ALU: begin
                regWr = 1'b1;
                if (is_rtype) begin
                    regDst = 2'b01;
                    aluOp  = alu_r;
                end else begin
                    aluSrc = 1'b1;
                    aluOp  = alu_i;
                    extOp  = ext_i;
                end
            end
            S_MEM_ADR, S_MEM_RD: begin
                aluSrc = 1'b1;
                extOp  = 1'b1;
            end
            S_MEM_WR: begin
                aluSrc = 1'b1;
                extOp  = 1'b1;
                memWr  = cnt_done;
            end
            S_WB_MEM: begin
                aluSrc   = 1'b1;
                extOp    = 1'b1;
                regWr    = 1'b1;
                memToReg = 2'b01;
            end
            S_BRANCH: begin
                aluOp  = ALU_SUB;
                extOp  = 1'b1;
                pcWr   = zero;
                npcSel = 2'b01;
            end
            S_JUMP: begin
                pcWr = 1'b1;
                if (is_jr) begin
                    npcSel = 2'b11;
                end else begin
                    npcSel = 2'b10;
                    if (is_jal) begin
                        regWr    = 1'b1;
                        regDst   = 2'b10;
                        memToReg = 2'b10;
                    end
                end
            end
            default: ;
        endcase
        // Reset must suppress any write from an aborted instruction within the same cycle.
        if (rst) begin
            pcWr     = 1'b0;
            irWr     = 1'b0;
            regWr    = 1'b0;
            memWr    = 1'b0;
            regDst   = 2'b00;
            aluSrc   = 1'b0;
            aluOp    = ALU_ADD;
            extOp    = 1'b0;
            memToReg = 2'b00;
            npcSel   = 2'b00;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (MEM_WAIT=2): per-cycle expected output vectors for each instruction class.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = 32'h0;
    logic        zero = 1'b0;
    logic        pcWr, irWr, regWr, memWr, aluSrc, extOp, illegal;
    logic [1:0]  regDst, memToReg, npcSel;
    logic [4:0]  aluOp;
    logic [3:0]  state;

    int nvec = 0;
    int nerr = 0;

    mc_ctrl #(.MEM_WAIT(2)) dut (
        .clk(clk), .rst(rst), .ins(ins), .zero(zero),
        .pcWr(pcWr), .irWr(irWr), .regWr(regWr), .memWr(memWr),
        .regDst(regDst), .aluSrc(aluSrc), .aluOp(aluOp), .extOp(extOp),
        .memToReg(memToReg), .npcSel(npcSel), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {state,pcWr,irWr,regWr,memWr,regDst,aluSrc,aluOp,extOp,memToReg,npcSel,illegal}
    wire [21:0] obs = {state, pcWr, irWr, regWr, memWr, regDst, aluSrc, aluOp, extOp,
                       memToReg, npcSel, illegal};

    function automatic logic [21:0] ev(input int st, input int pw, input int iw, input int rw,
                                       input int mw, input int rd, input int as, input int ao,
                                       input int eo, input int mr, input int ns, input int il);
        return {4'(st), 1'(pw), 1'(iw), 1'(rw), 1'(mw), 2'(rd), 1'(as), 5'(ao), 1'(eo),
                2'(mr), 2'(ns), 1'(il)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] f;
        f = ev(0,1,1,0,0,0,0,0,0,0,0,0);
        #2;
        nvec++;
        if (obs !== 22'h0) begin
            nerr++;
            $display("FAIL reset_hold: got %h expected %h", obs, 22'h0);
        end
        step();
        step();
        nvec++;
        if (obs !== 22'h0) begin
            nerr++;
            $display("FAIL reset_hold_edges: got %h expected %h", obs, 22'h0);
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (obs !== f) begin
            nerr++;
            $display("FAIL reset_release_fetch: got %h expected %h", obs, f);
        end
    endtask

    task automatic test_addu();
        logic [21:0] tbl [5];
        ins = 32'h00221821;
        tbl = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(8,0,0,1,0,1,0,0,0,0,0,0),
                ev(0,1,1,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (obs !== tbl[i]) begin
                nerr++;
                $display("FAIL addu cyc%0d: got %h expected %h", i, obs, tbl[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_r_arith();
        logic [31:0] code [5];
        int          aop  [5];
        logic [21:0] tbl  [5];
        code = '{32'h00221823, 32'h00221824, 32'h00221825, 32'h0022182A, 32'h00021080};
        aop  = '{1, 2, 3, 4, 5};
        for (int k = 0; k < 5; k++) begin
            ins = code[k];
            tbl = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                    ev(2,0,0,0,0,0,0,aop[k],0,0,0,0), ev(8,0,0,1,0,1,0,aop[k],0,0,0,0),
                    ev(0,1,1,0,0,0,0,0,0,0,0,0)};
            for (int i = 0; i < 5; i++) begin
                nvec++;
                if (obs !== tbl[i]) begin
                    nerr++;
                    $display("FAIL r_arith ins=%h cyc%0d: got %h expected %h", code[k], i, obs, tbl[i]);
                end
                if (i < 4) step();
            end
        end
    endtask

    task automatic test_i_arith();
        logic [31:0] code [3];
        int          aop  [3];
        int          eop  [3];
        logic [21:0] tbl  [5];
        code = '{32'h34220005, 32'h24220005, 32'h3C010005};
        aop  = '{3, 0, 6};
        eop  = '{0, 1, 0};
        for (int k = 0; k < 3; k++) begin
            ins = code[k];
            tbl = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                    ev(3,0,0,0,0,0,1,aop[k],eop[k],0,0,0), ev(8,0,0,1,0,0,1,aop[k],eop[k],0,0,0),
                    ev(0,1,1,0,0,0,0,0,0,0,0,0)};
            for (int i = 0; i < 5; i++) begin
                nvec++;
                if (obs !== tbl[i]) begin
                    nerr++;
                    $display("FAIL i_arith ins=%h cyc%0d: got %h expected %h", code[k], i, obs, tbl[i]);
                end
                if (i < 4) step();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] lw_t [8];
        logic [21:0] sw_t [7];
        ins = 32'h8C050004;
        lw_t = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                 ev(4,0,0,0,0,0,1,0,1,0,0,0), ev(5,0,0,0,0,0,1,0,1,0,0,0),
                 ev(5,0,0,0,0,0,1,0,1,0,0,0), ev(5,0,0,0,0,0,1,0,1,0,0,0),
                 ev(7,0,0,1,0,0,1,0,1,1,0,0), ev(0,1,1,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (obs !== lw_t[i]) begin
                nerr++;
                $display("FAIL lw cyc%0d: got %h expected %h", i, obs, lw_t[i]);
            end
            if (i < 7) step();
        end
        ins = 32'hAC050004;
        sw_t = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                 ev(4,0,0,0,0,0,1,0,1,0,0,0), ev(6,0,0,0,0,0,1,0,1,0,0,0),
                 ev(6,0,0,0,0,0,1,0,1,0,0,0), ev(6,0,0,0,1,0,1,0,1,0,0,0),
                 ev(0,1,1,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            nvec++;
            if (obs !== sw_t[i]) begin
                nerr++;
                $display("FAIL sw cyc%0d: got %h expected %h", i, obs, sw_t[i]);
            end
            if (i < 6) step();
        end
    endtask

    task automatic test_beq();
        logic [21:0] tbl [4];
        ins = 32'h10220003;
        for (int z = 1; z >= 0; z--) begin
            zero = 1'(z);
            tbl = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                    ev(9,z,0,0,0,0,0,1,1,0,1,0), ev(0,1,1,0,0,0,0,0,0,0,0,0)};
            for (int i = 0; i < 4; i++) begin
                nvec++;
                if (obs !== tbl[i]) begin
                    nerr++;
                    $display("FAIL beq zero=%0d cyc%0d: got %h expected %h", z, i, obs, tbl[i]);
                end
                if (i < 3) step();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [31:0] code [3];
        logic [21:0] jst  [3];
        logic [21:0] tbl  [4];
        code = '{32'h0C000010, 32'h08000010, 32'h03E00008};
        jst  = '{ev(10,1,0,1,0,2,0,0,0,2,2,0), ev(10,1,0,0,0,0,0,0,0,0,2,0),
                 ev(10,1,0,0,0,0,0,0,0,0,3,0)};
        for (int k = 0; k < 3; k++) begin
            ins = code[k];
            tbl = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,0),
                    jst[k], ev(0,1,1,0,0,0,0,0,0,0,0,0)};
            for (int i = 0; i < 4; i++) begin
                nvec++;
                if (obs !== tbl[i]) begin
                    nerr++;
                    $display("FAIL jump ins=%h cyc%0d: got %h expected %h", code[k], i, obs, tbl[i]);
                end
                if (i < 3) step();
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] code [2];
        logic [21:0] tbl  [3];
        code = '{32'hFC000000, 32'h00000027};
        tbl  = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,0,0,0,0,0,0,0,0,1),
                 ev(0,1,1,0,0,0,0,0,0,0,0,0)};
        for (int k = 0; k < 2; k++) begin
            ins = code[k];
            for (int i = 0; i < 3; i++) begin
                nvec++;
                if (obs !== tbl[i]) begin
                    nerr++;
                    $display("FAIL illegal ins=%h cyc%0d: got %h expected %h", code[k], i, obs, tbl[i]);
                end
                if (i < 2) step();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] pre  [4];
        logic [21:0] post [4];
        logic [21:0] f;
        logic [21:0] swt  [7];
        f = ev(0,1,1,0,0,0,0,0,0,0,0,0);
        // Abort addu in WB_ALU.
        ins = 32'h00221821;
        pre = '{f, ev(1,0,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,0,0,0,0,0,0),
                ev(8,0,0,1,0,1,0,0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (obs !== pre[i]) begin
                nerr++;
                $display("FAIL rst_mid_pre cyc%0d: got %h expected %h", i, obs, pre[i]);
            end
            if (i < 3) step();
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (obs !== 22'h0) begin
            nerr++;
            $display("FAIL rst_mid_wb_alu: got %h expected %h", obs, 22'h0);
        end
        #1 rst = 1'b0;
        #1;
        post = '{f, ev(1,0,0,0,0,0,0,0,0,0,0,0), ev(2,0,0,0,0,0,0,0,0,0,0,0),
                 ev(8,0,0,1,0,1,0,0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (obs !== post[i]) begin
                nerr++;
                $display("FAIL rst_mid_post cyc%0d: got %h expected %h", i, obs, post[i]);
            end
            step();
        end
        // Abort sw on its write cycle; the wait counter must restart from zero.
        ins = 32'hAC050004;
        swt = '{f, ev(1,0,0,0,0,0,0,0,0,0,0,0), ev(4,0,0,0,0,0,1,0,1,0,0,0),
                ev(6,0,0,0,0,0,1,0,1,0,0,0), ev(6,0,0,0,0,0,1,0,1,0,0,0),
                ev(6,0,0,0,1,0,1,0,1,0,0,0), f};
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (obs !== swt[i]) begin
                nerr++;
                $display("FAIL rst_sw_pre cyc%0d: got %h expected %h", i, obs, swt[i]);
            end
            if (i < 5) step();
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (obs !== 22'h0) begin
            nerr++;
            $display("FAIL rst_mid_mem_wr: got %h expected %h", obs, 22'h0);
        end
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) begin
            nvec++;
            if (obs !== swt[i]) begin
                nerr++;
                $display("FAIL rst_sw_rerun cyc%0d: got %h expected %h", i, obs, swt[i]);
            end
            if (i < 6) step();
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_r_arith();
        test_i_arith();
        test_back_to_back();
        test_beq();
        test_jump();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the multi-cycle variant of the MIPS core.
- Replaces the per-instruction combinational decoder.
- Sequences shared datapath resources (PC, IR, register file, ALU, data memory) over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, one instruction at a time.
- Decodes opcode/funct from the IR output and drives all datapath enables and mux selects.

Parameters:
MEM_WAIT, 0, extra wait cycles held in MEM_RD/MEM_WR before the data memory result is used (0..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
ins  input  32  instruction from IR (stable from end of FETCH to next FETCH)
zero  input  1  ALU zero flag
pcWr  output  1  PC register write enable
irWr  output  1  IR write enable
regWr  output  1  register file write enable
memWr  output  1  data memory write enable
regDst  output  2  write-register select: 00 rt, 01 rd, 10 $31
aluSrc  output  1  ALU B operand: 0 busB, 1 ext_imm
aluOp  output  5  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 LUI
extOp  output  1  1 sign-extend, 0 zero-extend
memToReg  output  2  write-back source: 00 ALU, 01 DM, 10 PC
npcSel  output  2  next-PC: 00 PC+4, 01 branch target, 10 jump target, 11 busA
state  output  4  current state encoding (debug)
illegal  output  1  one-cycle pulse in DECODE on unsupported instruction

Behaviour:
- Supported instructions:
  - R-type (op 000000) by funct: addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - I/J-type by op: ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State encoding: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEM_ADR 4, MEM_RD 5, MEM_WR 6, WB_MEM 7, WB_ALU 8, BRANCH 9, JUMP 10. Codes 11..15 are unreachable and return to FETCH on the next edge.
- Reset:
  - rst high: state = FETCH and the wait counter = 0 immediately (asynchronous).
  - While rst is high, pcWr, irWr, regWr, memWr and illegal are forced 0. All selects are 0.
  - First rising edge after rst falls performs a normal FETCH.
  - Reset mid-instruction aborts it; no partial register or memory write occurs after rst rises.
- Outputs are combinational from state and ins. Default 0 in every state unless listed.
- FETCH: irWr=1, pcWr=1, npcSel=00. Next state DECODE.
- DECODE:
  - No writes.
  - Next state by class: R-arith → EXE_R; ori/addiu/lui → EXE_I; lw/sw → MEM_ADR; beq → BRANCH; j/jal/jr → JUMP.
  - Unsupported opcode/funct: illegal=1, next state FETCH (treated as nop).
- EXE_R: aluSrc=0, aluOp from funct. Next state WB_ALU.
- EXE_I:
  - aluSrc=1.
  - ori: aluOp=OR, extOp=0. addiu: aluOp=ADD, extOp=1. lui: aluOp=LUI.
  - Next state WB_ALU.
- WB_ALU:
  - regWr=1, memToReg=00.
  - regDst=01 for R-type, 00 for I-type.
  - aluSrc/aluOp/extOp held as in the preceding EXE state.
  - Next state FETCH.
- MEM_ADR: aluSrc=1, aluOp=ADD, extOp=1. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR:
  - Address controls held as in MEM_ADR.
  - 4-bit counter counts 0..MEM_WAIT; the state is held until the count equals MEM_WAIT, then the counter clears.
  - MEM_WR: memWr=1 only in the final cycle (exactly one write pulse). Next state FETCH.
  - MEM_RD next state: WB_MEM.
- WB_MEM: regWr=1, regDst=00, memToReg=01, address controls held. Next state FETCH.
- BRANCH:
  - aluSrc=0, aluOp=SUB, extOp=1.
  - pcWr=zero, npcSel=01. Target is computed from the already-incremented PC.
  - Next state FETCH.
- JUMP:
  - pcWr=1. npcSel=10 for j/jal, 11 for jr.
  - jal: regWr=1, regDst=10, memToReg=10 (writes PC+4).
  - Next state FETCH.
- Cycle counts with MEM_WAIT=0: R/I-arith 4, lw 5, sw 4, beq 3, j/jal/jr 3. lw and sw each add MEM_WAIT cycles.
- At most one of pcWr/irWr, regWr, memWr is high in any cycle, except JUMP for jal (pcWr and regWr).

Test Plan:
- Reset check:
  - Assert rst asynchronously mid-cycle during WB_ALU → state=0 and regWr=0 before the next edge.
  - Release → FETCH with irWr=1, pcWr=1.
- addu $3,$1,$2 (0x00221821):
  - State sequence 0,1,2,8,0.
  - In state 8: regWr=1, regDst=01, aluOp=0, memToReg=00.
- lw $5,4($0) (0x8C050004) with MEM_WAIT=2:
  - Sequence 0,1,4,5,5,5,7,0.
  - regWr only in state 7 with memToReg=01.
  - sw 0xAC050004 → memWr high exactly one cycle (last MEM_WR cycle).
- beq (0x10220003):
  - zero=1 → pcWr=1, npcSel=01 in state 9.
  - zero=0 → pcWr=0.
  - Both cases return to FETCH after 3 cycles.
- jal 0x0C000010 → state 10 with pcWr=1, regWr=1, regDst=10, memToReg=10, npcSel=10. jr $31 (0x03E00008) → npcSel=11, regWr=0.
- Illegal op 0xFC000000 → illegal pulses for 1 cycle in DECODE, no write enables asserted, next state FETCH.
